// File: rtl/red_blob_tracker.sv
// Red-pixel classifier and per-frame bounding-box / pixel-count accumulator.
// Consumes H/S/V samples and publishes one result set per completed frame.
module red_blob_tracker #(
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int HUE_RED_LO = 20,
  parameter int HUE_RED_HI = 340,
  parameter int SAT_MIN    = 12,
  parameter int VAL_MIN    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [8:0]  in_H,
  input  logic [5:0]  in_S,
  input  logic [5:0]  in_V,
  output logic        out_mask,
  output logic        out_mask_valid,
  output logic [8:0]  box_x_min,
  output logic [8:0]  box_x_max,
  output logic [7:0]  box_y_min,
  output logic [7:0]  box_y_max,
  output logic [16:0] pix_count,
  output logic        found,
  output logic        result_valid
);

  localparam logic WAIT_SOF = 1'b0;
  localparam logic ACCUM    = 1'b1;

  localparam logic [8:0]  HUE_LO = 9'(HUE_RED_LO);
  localparam logic [8:0]  HUE_HI = 9'(HUE_RED_HI);
  localparam logic [5:0]  S_MIN  = 6'(SAT_MIN);
  localparam logic [5:0]  V_MIN  = 6'(VAL_MIN);
  localparam logic [8:0]  X_LAST = 9'(FRAME_W - 1);
  localparam logic [7:0]  Y_LAST = 8'(FRAME_H - 1);
  localparam logic [16:0] CNT_MAX = 17'h1FFFF;

  logic        state_q, state_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [8:0]  acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
  logic [7:0]  acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
  logic [16:0] acc_cnt_q, acc_cnt_d;
  logic        mask_q, mask_d, mask_valid_q, mask_valid_d;
  logic [8:0]  box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
  logic [7:0]  box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
  logic [16:0] pix_count_q, pix_count_d;
  logic        found_q, found_d, result_valid_q, result_valid_d;

  logic        hit;
  logic [8:0]  upd_x_min, upd_x_max;
  logic [7:0]  upd_y_min, upd_y_max;
  logic [16:0] upd_cnt;

  assign hit = in_valid & ((in_H <= HUE_LO) | (in_H >= HUE_HI)) &
               (in_S >= S_MIN) & (in_V >= V_MIN);

  // Accumulator values after folding in the current pixel at (x_q, y_q).
  always_comb begin
    upd_x_min = acc_x_min_q;
    upd_x_max = acc_x_max_q;
    upd_y_min = acc_y_min_q;
    upd_y_max = acc_y_max_q;
    upd_cnt   = acc_cnt_q;
    if (hit) begin
      if (acc_cnt_q == 17'd0) begin
        upd_x_min = x_q;
        upd_x_max = x_q;
        upd_y_min = y_q;
        upd_y_max = y_q;
      end else begin
        if (x_q < acc_x_min_q) upd_x_min = x_q;
        if (x_q > acc_x_max_q) upd_x_max = x_q;
        if (y_q < acc_y_min_q) upd_y_min = y_q;
        if (y_q > acc_y_max_q) upd_y_max = y_q;
      end
      if (acc_cnt_q != CNT_MAX) upd_cnt = acc_cnt_q + 17'd1;
    end
  end

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    acc_x_min_d    = acc_x_min_q;
    acc_x_max_d    = acc_x_max_q;
    acc_y_min_d    = acc_y_min_q;
    acc_y_max_d    = acc_y_max_q;
    acc_cnt_d      = acc_cnt_q;
    box_x_min_d    = box_x_min_q;
    box_x_max_d    = box_x_max_q;
    box_y_min_d    = box_y_min_q;
    box_y_max_d    = box_y_max_q;
    pix_count_d    = pix_count_q;
    found_d        = found_q;
    result_valid_d = 1'b0;

    mask_valid_d = in_valid & ((state_q == ACCUM) | in_sof);
    mask_d       = mask_valid_d & hit;

    if (in_valid) begin
      if (in_sof) begin
        // A start-of-frame pixel always restarts the frame, discarding any partial one.
        state_d     = ACCUM;
        x_d         = 9'd1;
        y_d         = 8'd0;
        acc_x_min_d = 9'd0;
        acc_x_max_d = 9'd0;
        acc_y_min_d = 8'd0;
        acc_y_max_d = 8'd0;
        acc_cnt_d   = hit ? 17'd1 : 17'd0;
      end else if (state_q == ACCUM) begin
        if (x_q == X_LAST && y_q == Y_LAST) begin
          box_x_min_d    = upd_x_min;
          box_x_max_d    = upd_x_max;
          box_y_min_d    = upd_y_min;
          box_y_max_d    = upd_y_max;
          pix_count_d    = upd_cnt;
          found_d        = (upd_cnt != 17'd0);
          result_valid_d = 1'b1;
          state_d        = WAIT_SOF;
          x_d            = 9'd0;
          y_d            = 8'd0;
          acc_x_min_d    = 9'd0;
          acc_x_max_d    = 9'd0;
          acc_y_min_d    = 8'd0;
          acc_y_max_d    = 8'd0;
          acc_cnt_d      = 17'd0;
        end else begin
          acc_x_min_d = upd_x_min;
          acc_x_max_d = upd_x_max;
          acc_y_min_d = upd_y_min;
          acc_y_max_d = upd_y_max;
          acc_cnt_d   = upd_cnt;
          if (x_q == X_LAST) begin
            x_d = 9'd0;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= WAIT_SOF;
      x_q            <= '0;
      y_q            <= '0;
      acc_x_min_q    <= '0;
      acc_x_max_q    <= '0;
      acc_y_min_q    <= '0;
      acc_y_max_q    <= '0;
      acc_cnt_q      <= '0;
      mask_q         <= 1'b0;
      mask_valid_q   <= 1'b0;
      box_x_min_q    <= '0;
      box_x_max_q    <= '0;
      box_y_min_q    <= '0;
      box_y_max_q    <= '0;
      pix_count_q    <= '0;
      found_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      acc_x_min_q    <= acc_x_min_d;
      acc_x_max_q    <= acc_x_max_d;
      acc_y_min_q    <= acc_y_min_d;
      acc_y_max_q    <= acc_y_max_d;
      acc_cnt_q      <= acc_cnt_d;
      mask_q         <= mask_d;
      mask_valid_q   <= mask_valid_d;
      box_x_min_q    <= box_x_min_d;
      box_x_max_q    <= box_x_max_d;
      box_y_min_q    <= box_y_min_d;
      box_y_max_q    <= box_y_max_d;
      pix_count_q    <= pix_count_d;
      found_q        <= found_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign out_mask       = mask_q;
  assign out_mask_valid = mask_valid_q;
  assign box_x_min      = box_x_min_q;
  assign box_x_max      = box_x_max_q;
  assign box_y_min      = box_y_min_q;
  assign box_y_max      = box_y_max_q;
  assign pix_count      = pix_count_q;
  assign found          = found_q;
  assign result_valid   = result_valid_q;

endmodule
